// File: rtl/seq_fifo_if.sv
// Handshake bundle for seq_fifo: the generator push side and the consumer ready/valid pop side.
interface seq_fifo_if;
   logic [15:0] seq_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output seq_in, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  seq_in, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/seq_fifo.sv
// First-word-fall-through FIFO buffering generator words; pushes that arrive when full are dropped.
// Optional running sum of accepted words is built when SEQ_FIFO_SUM_EN is defined.
module seq_fifo #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   seq_fifo_if.slave        bus,
   output logic [PTR_W:0]   count,
   output logic             overflow,
   output logic [15:0]      sum
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   function automatic logic [15:0] wrap_add16(input logic [15:0] a, input logic [15:0] b);
      return a + b;
   endfunction

   logic [15:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic full;
   logic pop;
   logic push_acc;
   logic pop_acc;

   assign full          = (count_q == FULL_CNT);
   assign bus.out_valid = (count_q != '0);
   assign bus.in_ready  = ~full;
   assign bus.out_data  = mem_q[rp_q];
   assign pop           = bus.out_valid & bus.out_ready;
   // clr masks both sides so a flush cycle never writes or advances the head.
   assign push_acc      = bus.in_valid & (~full | pop) & ~clr;
   assign pop_acc       = pop & ~clr;

   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clr) begin
         wp_d       = '0;
         rp_d       = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_acc) wp_d = wp_q + 1'b1;
         if (pop_acc)  rp_d = rp_q + 1'b1;
         case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (bus.in_valid & full & ~pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is data only; it carries no reset.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wp_q] <= bus.seq_in;
   end

   assign count    = count_q;
   assign overflow = overflow_q;

`ifdef SEQ_FIFO_SUM_EN
   logic [15:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr)           sum_d = '0;
      else if (push_acc) sum_d = wrap_add16(sum_q, bus.seq_in);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign sum = sum_q;
`else
   assign sum = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_fifo.sv
// Directed bench for seq_fifo (DEPTH=8): fill/overflow, full push+pop, wrap, clr and async reset.
module tb_seq_fifo;

   logic        clk;
   logic        reset;
   logic        clr;
   logic [3:0]  count;
   logic        overflow;
   logic [15:0] sum;

   int errors = 0;
   int checks = 0;

   logic [15:0] fib [8];

   seq_fifo_if bus ();

   seq_fifo #(.DEPTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .bus      (bus),
      .count    (count),
      .overflow (overflow),
      .sum      (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      bus.in_valid = 1'b1;
      bus.seq_in   = v;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      fib[0] = 16'h0001; fib[1] = 16'h0002; fib[2] = 16'h0003; fib[3] = 16'h0005;
      fib[4] = 16'h0008; fib[5] = 16'h000D; fib[6] = 16'h0015; fib[7] = 16'h0022;

      reset         = 1'b0;
      clr           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.seq_in    = 16'h0000;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_count", count, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_overflow", overflow, 0);
      check("rst_sum", sum, 0);
      reset = 1'b1;
      tick();

      push(16'h0001);
      check("first_out_valid", bus.out_valid, 1);
      check("first_out_data", bus.out_data, 16'h0001);
      check("first_count", count, 1);
      check("first_in_ready", bus.in_ready, 1);

      for (int i = 1; i < 8; i++) push(fib[i]);
      check("fill_count", count, 8);
      check("fill_in_ready", bus.in_ready, 0);
      check("fill_overflow", overflow, 0);
      push(16'h0037);
      check("ovf_count", count, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_head", bus.out_data, 16'h0001);

      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), bus.out_data, fib[i]);
         tick();
      end
      bus.out_ready = 1'b0;
      check("drain_empty_valid", bus.out_valid, 0);
      check("drain_empty_count", count, 0);
      check("ovf_sticky", overflow, 1);

      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_overflow", overflow, 0);
      for (int i = 0; i < 8; i++) push(fib[i]);
      check("refill_count", count, 8);
      bus.out_ready = 1'b1;
      push(16'hAAAA);
      check("fullpp_count", count, 8);
      check("fullpp_head", bus.out_data, 16'h0002);
      check("fullpp_overflow", overflow, 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("fullpp_drain_%0d", i), bus.out_data, (i == 7) ? 16'hAAAA : fib[i+1]);
         tick();
      end
      bus.out_ready = 1'b0;
      check("fullpp_empty", bus.out_valid, 0);

      for (int i = 0; i < 20; i++) begin
         push(16'(i));
         check($sformatf("wrap_data_%0d", i), bus.out_data, i);
         check($sformatf("wrap_cnt1_%0d", i), count, 1);
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         check($sformatf("wrap_cnt0_%0d", i), count, 0);
      end

      for (int i = 0; i < 9; i++) push(16'h0100 + 16'(i));
      bus.out_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.out_ready = 1'b0;
      check("preclr_count", count, 5);
      check("preclr_overflow", overflow, 1);
      check("preclr_head", bus.out_data, 16'h0103);
      clr = 1'b1;
      push(16'h1234);
      clr = 1'b0;
      check("clr_count", count, 0);
      check("clr_out_valid", bus.out_valid, 0);
      check("clr_ovf", overflow, 0);
      tick();
      check("clr_nostore", count, 0);
      push(16'h5555);
      check("postclr_data", bus.out_data, 16'h5555);
      check("postclr_count", count, 1);

      push(16'h0A0A);
      push(16'h0B0B);
      bus.out_ready = 1'b1;
      tick();
      check("middrain_count", count, 2);
      #1;
      reset = 1'b0;
      #1;
      check("async_out_valid", bus.out_valid, 0);
      check("async_count", count, 0);
      bus.out_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      push(16'hFFFF);
      push(16'h0002);
`ifdef SEQ_FIFO_SUM_EN
      check("sum_wrap", sum, 16'h0001);
`else
      check("sum_tied", sum, 16'h0000);
`endif
      check("sum_count", count, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
